// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - word-wide data-memory responder with self-clear, tohost register and access counters
module data_memory_responder #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1001_0000,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h1001_FFFC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] data_address,
    input  logic              write_enable,
    input  logic              read_enable,
    output logic [DATA_W-1:0] data,
    output logic              init_busy,
    output logic [DATA_W-1:0] tohost,
    output logic              done,
    output logic              err,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    // One bit wider than the address so BASE_ADDR + 4*DEPTH cannot wrap.
    localparam logic [ADDR_W:0] ARRAY_END = {1'b0, BASE_ADDR} + (ADDR_W+1)'(4 * DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  init_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  word_idx;
    logic              in_array;
    logic              misaligned;
    logic              is_tohost;
    logic              ready;
    logic              bad_access;
    logic              load_ok;
    logic              store_ok;
    logic              mem_store;

    // Address decode and request qualification.
    always_comb begin
        offset     = data_address - BASE_ADDR;
        word_idx   = IDX_W'(offset >> 2);
        in_array   = (data_address >= BASE_ADDR) && ({1'b0, data_address} < ARRAY_END);
        misaligned = (data_address[1:0] != 2'b00);
        is_tohost  = (data_address == TOHOST_ADDR);
        ready      = (state == ST_READY);
        bad_access = ready && (read_enable || write_enable)
                     && (misaligned || !(in_array || is_tohost));
        load_ok    = ready && read_enable && !bad_access;
        store_ok   = ready && write_enable && !bad_access;
        mem_store  = store_ok && in_array;
    end

    // Combinational load path; reads the pre-edge contents, so a same-cycle store is not visible.
    always_comb begin
        data = '0;
        if (ready && read_enable) begin
            if (in_array && !misaligned) begin
                data = mem[word_idx];
            end else if (is_tohost) begin
                data = tohost;
            end
        end
    end

    // Array writes: zero fill while clearing, qualified stores once ready; nothing while in reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                mem[init_cnt] <= '0;
            end else if (mem_store) begin
                mem[word_idx] <= write_data;
            end
        end
    end

    // Control FSM plus tohost, sticky flags and saturating access counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_busy <= 1'b1;
            tohost    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + IDX_W'(1);
                    if (init_cnt == LAST_IDX) begin
                        state     <= ST_READY;
                        init_busy <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (bad_access) begin
                        err <= 1'b1;
                    end
                    if (load_ok && (rd_cnt != 16'hFFFF)) begin
                        rd_cnt <= rd_cnt + 16'd1;
                    end
                    if (store_ok && (wr_cnt != 16'hFFFF)) begin
                        wr_cnt <= wr_cnt + 16'd1;
                    end
                    if (store_ok && is_tohost) begin
                        tohost <= write_data;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - randomized and directed bench for data_memory_responder against a behavioural model
module tb_data_memory_responder;

    localparam int            DEPTH  = 256;
    localparam longint        BASE   = 64'h1001_0000;
    localparam longint        TOHOST = 64'h1001_FFFC;
    localparam logic [31:0]   BASE32 = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] write_data;
    logic [31:0] data_address;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] data;
    logic        init_busy;
    logic [31:0] tohost;
    logic        done;
    logic        err;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    data_memory_responder dut (
        .clk          (clk),
        .rst          (rst),
        .write_data   (write_data),
        .data_address (data_address),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data         (data),
        .init_busy    (init_busy),
        .tohost       (tohost),
        .done         (done),
        .err          (err),
        .rd_cnt       (rd_cnt),
        .wr_cnt       (wr_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory as an array, clear sequence as a countdown.
    logic [31:0] m_mem [DEPTH];
    bit          m_ready;
    int          m_left;
    logic [31:0] m_tohost;
    bit          m_done;
    bit          m_err;
    int          m_rd;
    int          m_wr;

    function automatic void decode(input logic [31:0] a, output bit inarr, output int idx,
                                   output bit mis, output bit toh);
        longint la;
        la    = longint'(a);
        inarr = (la >= BASE) && (la < BASE + 4 * DEPTH);
        idx   = inarr ? int'((la - BASE) / 4) : 0;
        mis   = (la % 4) != 0;
        toh   = (la == TOHOST);
    endfunction

    always @(posedge clk) begin
        bit inarr, mis, toh;
        int idx;
        if (rst) begin
            m_ready  = 0;
            m_left   = DEPTH;
            m_tohost = 0;
            m_done   = 0;
            m_err    = 0;
            m_rd     = 0;
            m_wr     = 0;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
            end
        end else begin
            decode(data_address, inarr, idx, mis, toh);
            if ((read_enable || write_enable) && (mis || !(inarr || toh))) begin
                m_err = 1;
            end else begin
                if (read_enable) m_rd = (m_rd < 65535) ? m_rd + 1 : 65535;
                if (write_enable) begin
                    m_wr = (m_wr < 65535) ? m_wr + 1 : 65535;
                    if (toh) begin
                        m_tohost = write_data;
                        m_done   = 1;
                    end else begin
                        m_mem[idx] = write_data;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        bit inarr, mis, toh;
        int idx;
        logic [31:0] exp_data;
        if (chk_en) begin
            exp_data = 0;
            decode(data_address, inarr, idx, mis, toh);
            if (m_ready && read_enable) begin
                if (inarr && !mis) exp_data = m_mem[idx];
                else if (toh)      exp_data = m_tohost;
            end
            check("data", data, exp_data);
            check("init_busy", {31'b0, init_busy}, {31'b0, !m_ready});
            check("tohost", tohost, m_tohost);
            check("done", {31'b0, done}, {31'b0, m_done});
            check("err", {31'b0, err}, {31'b0, m_err});
            check("rd_cnt", {16'b0, rd_cnt}, 32'(m_rd));
            check("wr_cnt", {16'b0, wr_cnt}, 32'(m_wr));
        end
    end

    task automatic op(input bit re, input bit we, input logic [31:0] a, input logic [31:0] wd);
        read_enable  = re;
        write_enable = we;
        data_address = a;
        write_data   = wd;
        @(negedge clk);
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
        read_enable  = 0;
        write_enable = 0;
    endtask

    // Assumes the caller just released rst right after the last edge that sampled it high.
    task automatic measure_init(input string name);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (init_busy) cnt++;
            else break;
        end
        check(name, cnt, 256);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int kind;
        logic [31:0] a;
        rst          = 1;
        read_enable  = 0;
        write_enable = 0;
        data_address = 0;
        write_data   = 0;
        @(posedge clk);
        #1;
        chk_en = 1;
        @(posedge clk);
        #1;
        rst = 0;
        measure_init("init_len");

        op(0, 1, 32'h1001_0008, 32'hDEADBEEF); fin();
        op(1, 0, 32'h1001_0008, 0); check("st_ld_data", data, 32'hDEADBEEF); fin();
        check("st_ld_wr_cnt", {16'b0, wr_cnt}, 1);
        check("st_ld_rd_cnt", {16'b0, rd_cnt}, 1);

        op(1, 0, BASE32, 0); check("clr_first", data, 0); fin();
        op(1, 0, 32'h1001_03FC, 0); check("clr_last", data, 0); fin();

        op(0, 1, BASE32, 32'h11); fin();
        op(1, 1, BASE32, 32'h22); check("rbw_old", data, 32'h11); fin();
        op(1, 0, BASE32, 0); check("rbw_new", data, 32'h22); fin();
        check("rbw_rd_cnt", {16'b0, rd_cnt}, 5);
        check("rbw_wr_cnt", {16'b0, wr_cnt}, 3);

        op(1, 0, 32'h1001_0002, 0); check("mis_data", data, 0); fin();
        check("mis_err", {31'b0, err}, 1);
        op(0, 1, 32'h2000_0000, 32'h55); fin();
        check("err_rd_cnt", {16'b0, rd_cnt}, 5);
        check("err_wr_cnt", {16'b0, wr_cnt}, 3);
        op(1, 0, BASE32, 0); check("err_mem_kept", data, 32'h22); fin();

        op(0, 1, 32'h1001_FFFC, 32'h1); fin();
        check("th_done", {31'b0, done}, 1);
        check("th_value", tohost, 1);
        op(1, 0, 32'h1001_FFFC, 0); check("th_load", data, 1); fin();

        rst = 1;
        fin();
        rst = 0;
        repeat (100) fin();
        rst = 1;
        fin();
        rst = 0;
        check("rst_done", {31'b0, done}, 0);
        check("rst_err", {31'b0, err}, 0);
        measure_init("init_restart");

        for (int i = 0; i < 3000; i++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2: a = BASE32 + 32'($urandom_range(0, 15) * 4);
                3, 4:    a = BASE32 + 32'($urandom_range(0, 255) * 4);
                5:       a = BASE32 + 32'($urandom_range(0, 1023)) | 32'h1;
                6:       a = 32'h1001_FFFC;
                7:       a = BASE32 - 32'd4;
                8:       a = BASE32 + 32'h400;
                default: a = $urandom;
            endcase
            rst          = (i == 1500);
            read_enable  = 1'($urandom);
            write_enable = 1'($urandom);
            data_address = a;
            write_data   = $urandom;
            @(posedge clk);
            #1;
        end
        rst = 0;
        read_enable  = 0;
        write_enable = 0;
        repeat (300) fin();

        for (int i = 0; i < 65540; i++) begin
            read_enable  = 1;
            write_enable = 1;
            data_address = BASE32 + 32'd4;
            write_data   = 32'(i);
            @(posedge clk);
            #1;
        end
        read_enable  = 0;
        write_enable = 0;
        check("sat_rd_cnt", {16'b0, rd_cnt}, 32'hFFFF);
        check("sat_wr_cnt", {16'b0, wr_cnt}, 32'hFFFF);
        fin();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Synthesizable responder for the core's data-memory port. It answers `MemRead`/`MemWrite` from the RISCV pipeline's MEM stage with word-wide load data and stores. After reset it runs a self-clear sequence over the whole array, and it provides a memory-mapped `tohost` register, an error flag and access counters for end-of-program checking. It replaces the behavioural data memory in the system bench and in FPGA builds.

## Interface
Parameters:
- `DATA_W`, 32, data word width
- `ADDR_W`, 32, byte-address width
- `DEPTH`, 256, number of words in the array (power of two)
- `BASE_ADDR`, 32'h1001_0000, byte address of word 0
- `TOHOST_ADDR`, 32'h1001_FFFC, byte address of the `tohost` register (outside the array)

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `write_data`  in  DATA_W  store data
- `data_address`  in  ADDR_W  byte address
- `write_enable`  in  1  store request (`MemWrite`)
- `read_enable`  in  1  load request (`MemRead`)
- `data`  out  DATA_W  load data (to `Data_memory_output`)
- `init_busy`  out  1  array clear in progress
- `tohost`  out  DATA_W  last value stored to `TOHOST_ADDR`
- `done`  out  1  sticky, set by a store to `TOHOST_ADDR`
- `err`  out  1  sticky, set by a misaligned or unmapped access
- `rd_cnt`  out  16  accepted loads, saturating
- `wr_cnt`  out  16  accepted stores, saturating

## Operation
Address decode:
- `in_array` = (`data_address` >= `BASE_ADDR`) and (`data_address` < `BASE_ADDR` + 4·`DEPTH`).
- Word index = (`data_address` − `BASE_ADDR`)[log2(DEPTH)+1:2].
- `misaligned` = `data_address[1:0]` != 0.
- `is_tohost` = (`data_address` == `TOHOST_ADDR`).

FSM:
- Two states, INIT and READY.
- Reset enters INIT with `init_cnt` = 0.
- INIT: each cycle writes 0 to word `init_cnt`, then increments it. When `init_cnt` = DEPTH−1 the FSM moves to READY on that edge.
- READY: stays in READY until reset.

Loads:
- `data` is combinational.
- `data` = array[index] when READY, `read_enable`, `in_array` and not `misaligned`.
- `data` = `tohost` when READY, `read_enable` and `is_tohost`.
- `data` = 0 in every other case.

Stores (READY only, `write_enable` = 1):
- Aligned and `in_array`: array[index] ← `write_data`.
- `is_tohost`: `tohost` ← `write_data` and `done` ← 1.
- Any other store is dropped.

Error flag:
- In READY, an access with `read_enable` or `write_enable` set that is misaligned, or that is neither `in_array` nor `is_tohost`, sets `err`.
- `err` is sticky until reset.

Counters:
- `rd_cnt` / `wr_cnt` increment on each accepted load / store.
- "Accepted" means READY, not erroneous, and the corresponding enable set.
- Both counters saturate at 16'hFFFF.

Requests during INIT:
- Loads return 0; stores are dropped.
- Counters and `err` do not change.
- The core is expected to be held off via `en` while `init_busy` = 1.

## Timing
Reset values (rst sampled high at an edge):
- State INIT, `init_cnt` 0, `init_busy` 1.
- `tohost` 0, `done` 0, `err` 0, `rd_cnt` 0, `wr_cnt` 0.
- Array contents are not reset directly; the clear sequence zeroes them.

Clear sequence:
- Takes exactly DEPTH cycles after the first edge with `rst` low.
- `init_busy` falls on the DEPTH-th such edge.
- The first request can be accepted in the following cycle.

Load and store latency:
- Load: 0 cycles; `data` is valid in the same cycle as the request.
- Store: visible to a load starting on the cycle after the write edge.

Simultaneous `read_enable` and `write_enable` to the same word:
- `data` shows the old contents in that cycle (read-before-write).
- The write commits at the edge.
- Both counters increment.

Reset asserted mid-operation (including mid-INIT):
- Any pending store is dropped.
- The FSM restarts INIT from index 0.
- `done`, `err` and the counters clear.

Counter boundary: at 16'hFFFF a further access leaves the counter at 16'hFFFF.

## Test plan
- Clear sequence: pulse `rst` for 2 cycles with DEPTH=256 → `init_busy` is high for exactly 256 cycles. Afterwards, loads of `BASE_ADDR` and `BASE_ADDR`+0x3FC return 0.
- Store then load: store 0xDEADBEEF to 0x1001_0008, then load 0x1001_0008 on the next cycle → `data` = 0xDEADBEEF, `wr_cnt` = 1, `rd_cnt` = 1.
- Same-cycle read and write: word 0 holds 0x11. Drive a load and a store of 0x22 to 0x1001_0000 in the same cycle → `data` = 0x11 that cycle, then 0x22 on the next load.
- Errors: load 0x1001_0002 and store to 0x2000_0000 → `err` = 1, `data` = 0, memory unchanged, counters unchanged.
- tohost: store 0x0000_0001 to 0x1001_FFFC → `done` = 1, `tohost` = 1, a load of 0x1001_FFFC returns 1.
- Reset mid-INIT and saturation: assert `rst` at `init_cnt` = 100 → INIT restarts and `init_busy` lasts another 256 cycles. Separately, force `rd_cnt` to 0xFFFE and issue 3 loads → `rd_cnt` = 0xFFFF.
